alu_exec_ctrl: RTL and testbench
================================

Name: alu_exec_ctrl

Overview:
Execute-stage sequencer that sits directly upstream and downstream of the 16-bit combinational ALU. It accepts one decoded operation per handshake and reads operands from an internal 8x16 register file. It drives the ALU inputs, captures the ALU result and flags, and writes them back to the register file and a flag register. The ALU itself is instantiated outside this block.

Parameters:
NREG, 8, register-file depth (index width = 3; fixed for this revision)
DIV_ZERO_RESULT, 16'hFFFF, value written when a divide has a zero divisor

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
issue_valid  in  1  operation offered
issue_ready  out  1  block can accept an operation
issue_func  in  4  ALU function code, passed to alu_func
issue_dst  in  3  destination register (also the ALU b operand)
issue_src  in  3  source register (ALU a operand when issue_use_imm=0)
issue_use_imm  in  1  1: a operand = issue_imm
issue_imm  in  16  immediate operand
issue_use_carry  in  1  1: alu_cin = stored C flag, else 0
issue_wr_en  in  1  write the result to R[dst]
issue_flag_en  in  1  update the flag register
alu_a  out  16  to ALU a (source)
alu_b  out  16  to ALU b (destination value)
alu_func  out  4  to ALU function select
alu_cin  out  1  to ALU carry in
alu_out  in  16  ALU result
alu_c, alu_z, alu_v, alu_s  in  1 each  ALU flags
wb_valid  out  1  one-cycle writeback strobe
wb_dst  out  3  writeback register index
wb_data  out  16  writeback data
flags  out  4  {C,Z,V,S} flag register
dbg_rd_addr  in  3  debug read index
dbg_rd_data  out  16  combinational R[dbg_rd_addr]

Behaviour:
- Reset (async, any state):
  - state returns to IDLE; R0..R7 = 0; flags = 0.
  - All latched instruction fields = 0, so alu_a, alu_b, alu_func and alu_cin = 0.
  - wb_valid = 0, wb_dst = 0, wb_data = 0.
  - issue_ready = 0 while rst is high.
  - An operation in flight is discarded: no register or flag write.
- FSM states: IDLE, EXEC, WB. Transitions are IDLE->EXEC on issue_valid&&issue_ready, EXEC->WB always, WB->IDLE always.
- issue_ready = 1 only in IDLE with rst low. issue_valid has no effect outside IDLE.
- Accept edge E0:
  - latch func, dst, use_carry, wr_en and flag_en;
  - latch a_op = use_imm ? imm : R[src];
  - latch b_op = R[dst];
  - latch cin = use_carry ? flags.C : 0.
  - The operands are read from register-file contents before E0; no other write can be pending.
- alu_a, alu_b, alu_func and alu_cin are driven from the latched registers at all times and stay stable through EXEC.
- Edge E1 (end of EXEC): capture the result and flags into the result registers.
  - Normal case: result = alu_out, flags from alu_c/z/v/s.
  - Divide by zero (func==4'b1000 and a_op==0): ALU outputs are ignored; result = DIV_ZERO_RESULT, captured flags C=0, Z=0, V=1, S=1.
- WB cycle (between E1 and E2):
  - wb_valid = wr_en for exactly one cycle.
  - wb_dst = latched dst; wb_data = captured result.
  - wb_dst and wb_data hold their values after WB until the next E1 capture.
- Edge E2:
  - if wr_en, R[dst] = result;
  - if flag_en, flags = captured flags, otherwise flags are unchanged.
  - The next operation can be accepted at E2+1 at the earliest.
- Timing: accept-to-writeback latency is 2 cycles; peak throughput is 1 op per 3 cycles.
- src==dst is legal: both ALU operands equal the old R[dst].
- wr_en=0 with flag_en=1 is a compare/test: flags update, no register write, no wb_valid.
- Function codes 0xE/0xF pass through unchanged; the ALU returns 0 (Z=1).
- dbg_rd_data reflects a register write from the cycle after E2.

Test Plan:
- Reset check: assert rst mid-stream, then release. Required: flags=0, wb_valid=0, dbg_rd_data=0 for all 8 indices, issue_ready=0 during rst and 1 after.
- Immediate load: OR, dst=1, imm=0x1234, wr_en=1 into R1=0. Required: alu_a=0x1234 during EXEC, wb_valid high exactly 2 cycles after accept with wb_data=0x1234, then R1=0x1234.
- Carry chain:
  - R1=0xFFFF, R2=0x0001; ADD dst=2 src=1 flag_en=1. Required: R2=0x0000, flags C=1 Z=1 V=0 S=0.
  - Then ADD dst=3 (R3=0), imm=0, use_carry=1. Required: alu_cin=1, R3=0x0001.
- Divide by zero: R4=0x0010; DIV dst=4 imm=0 flag_en=1. Required: R4=0xFFFF, flags C=0 Z=0 V=1 S=1.
- Compare only: R5=0x0007; SUB dst=5 imm=7 wr_en=0 flag_en=1. Required: no wb_valid, R5 stays 0x0007, Z=1.
- Back-to-back and abort:
  - Hold issue_valid high for 3 ops. Required: accepts occur exactly every 3 cycles.
  - Assert rst during EXEC. Required: the target register is unchanged and wb_valid never rises.

Source files
------------

// File: rtl/alu_exec_ctrl_if.sv
// Issue, ALU-side and writeback/debug signals of the execute-stage sequencer.
// The slave modport is the sequencer's view; master is the issuing/ALU side.
interface alu_exec_ctrl_if;
   logic        issue_valid;
   logic        issue_ready;
   logic [3:0]  issue_func;
   logic [2:0]  issue_dst;
   logic [2:0]  issue_src;
   logic        issue_use_imm;
   logic [15:0] issue_imm;
   logic        issue_use_carry;
   logic        issue_wr_en;
   logic        issue_flag_en;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [3:0]  alu_func;
   logic        alu_cin;
   logic [15:0] alu_out;
   logic        alu_c;
   logic        alu_z;
   logic        alu_v;
   logic        alu_s;
   logic        wb_valid;
   logic [2:0]  wb_dst;
   logic [15:0] wb_data;
   logic [3:0]  flags;
   logic [2:0]  dbg_rd_addr;
   logic [15:0] dbg_rd_data;

   modport slave (
      input  issue_valid, issue_func, issue_dst, issue_src, issue_use_imm,
             issue_imm, issue_use_carry, issue_wr_en, issue_flag_en,
             alu_out, alu_c, alu_z, alu_v, alu_s, dbg_rd_addr,
      output issue_ready, alu_a, alu_b, alu_func, alu_cin,
             wb_valid, wb_dst, wb_data, flags, dbg_rd_data
   );

   modport master (
      output issue_valid, issue_func, issue_dst, issue_src, issue_use_imm,
             issue_imm, issue_use_carry, issue_wr_en, issue_flag_en,
             alu_out, alu_c, alu_z, alu_v, alu_s, dbg_rd_addr,
      input  issue_ready, alu_a, alu_b, alu_func, alu_cin,
             wb_valid, wb_dst, wb_data, flags, dbg_rd_data
   );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer around an external 16-bit ALU: IDLE -> EXEC -> WB,
// owning the 8x16 register file and the {C,Z,V,S} flag register.
module alu_exec_ctrl #(
   parameter int          NREG            = 8,
   parameter logic [15:0] DIV_ZERO_RESULT = 16'hFFFF
) (
   input logic            clk,
   input logic            rst,
   alu_exec_ctrl_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] WB   = 2'd2;
   localparam logic [3:0] FUNC_DIV = 4'b1000;

   logic [1:0]  state_reg;
   logic [15:0] rf_reg [NREG];
   logic [15:0] a_reg;
   logic [15:0] b_reg;
   logic [3:0]  func_reg;
   logic [2:0]  dst_reg;
   logic        cin_reg;
   logic        wr_en_reg;
   logic        flag_en_reg;
   logic [15:0] res_reg;
   logic [3:0]  cap_flags_reg;
   logic [3:0]  flags_reg;
   logic [2:0]  wb_dst_reg;
   logic        accept;
   logic        commit_wr;
   logic        div_zero;

   assign bus.issue_ready = (state_reg == IDLE) && !rst;
   assign accept          = bus.issue_valid && bus.issue_ready;
   assign commit_wr       = (state_reg == WB) && wr_en_reg;
   assign div_zero        = (func_reg == FUNC_DIV) && (a_reg == 16'h0000);

   // Each register owns its write port; a write lands only on the WB->IDLE edge.
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               rf_reg[gi] <= 16'h0000;
            else if (commit_wr && (dst_reg == 3'(gi)))
               rf_reg[gi] <= res_reg;
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         a_reg         <= 16'h0000;
         b_reg         <= 16'h0000;
         func_reg      <= 4'h0;
         dst_reg       <= 3'd0;
         cin_reg       <= 1'b0;
         wr_en_reg     <= 1'b0;
         flag_en_reg   <= 1'b0;
         res_reg       <= 16'h0000;
         cap_flags_reg <= 4'h0;
         flags_reg     <= 4'h0;
         wb_dst_reg    <= 3'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  func_reg    <= bus.issue_func;
                  dst_reg     <= bus.issue_dst;
                  wr_en_reg   <= bus.issue_wr_en;
                  flag_en_reg <= bus.issue_flag_en;
                  a_reg       <= bus.issue_use_imm ? bus.issue_imm : rf_reg[bus.issue_src];
                  b_reg       <= rf_reg[bus.issue_dst];
                  cin_reg     <= bus.issue_use_carry ? flags_reg[3] : 1'b0;
                  state_reg   <= EXEC;
               end
            end
            EXEC: begin
               // A zero divisor overrides whatever the ALU produced.
               if (div_zero) begin
                  res_reg       <= DIV_ZERO_RESULT;
                  cap_flags_reg <= 4'b0011;
               end else begin
                  res_reg       <= bus.alu_out;
                  cap_flags_reg <= {bus.alu_c, bus.alu_z, bus.alu_v, bus.alu_s};
               end
               wb_dst_reg <= dst_reg;
               state_reg  <= WB;
            end
            WB: begin
               if (flag_en_reg)
                  flags_reg <= cap_flags_reg;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.alu_a       = a_reg;
   assign bus.alu_b       = b_reg;
   assign bus.alu_func    = func_reg;
   assign bus.alu_cin     = cin_reg;
   assign bus.wb_valid    = commit_wr;
   assign bus.wb_dst      = wb_dst_reg;
   assign bus.wb_data     = res_reg;
   assign bus.flags       = flags_reg;
   assign bus.dbg_rd_data = rf_reg[bus.dbg_rd_addr];
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural ALU stand-in, a register/flag
// reference model and a writeback scoreboard.
module tb_alu_exec_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_exec_ctrl_if bus();
   alu_exec_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [2:0]  dst;
      logic [15:0] data;
   } wb_t;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] mreg [8];
   logic [3:0]  mflags;
   wb_t         sb [$];

   // {C,Z,V,S,result}: ADD=0, SUB=1 (b-a-cin), OR=2, AND=3, XOR=4, DIV=8 (b/a)
   function automatic logic [19:0] ref_alu(input logic [3:0] f, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin);
      logic [16:0] t;
      logic [15:0] r;
      logic        c;
      logic        v;
      t = 17'h0; r = 16'h0; c = 1'b0; v = 1'b0;
      case (f)
         4'h0: begin
            t = 17'(a) + 17'(b) + 17'(cin);
            r = t[15:0]; c = t[16];
            v = (a[15] == b[15]) && (r[15] != a[15]);
         end
         4'h1: begin
            t = 17'(b) - 17'(a) - 17'(cin);
            r = t[15:0]; c = t[16];
            v = (a[15] != b[15]) && (r[15] != b[15]);
         end
         4'h2: r = a | b;
         4'h3: r = a & b;
         4'h4: r = a ^ b;
         4'h8: r = (a == 16'h0) ? 16'h0 : b / a;
         default: r = 16'h0;
      endcase
      return {c, (r == 16'h0), v, r[15], r};
   endfunction

   always_comb begin
      logic [19:0] t2;
      t2 = ref_alu(bus.alu_func, bus.alu_a, bus.alu_b, bus.alu_cin);
      bus.alu_out = t2[15:0];
      {bus.alu_c, bus.alu_z, bus.alu_v, bus.alu_s} = t2[19:16];
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_wb(input string tag);
      wb_t w;
      total++;
      assert (sb.size() != 0) else begin
         bad++;
         $error("FAIL %s.sb_empty observed=wb_valid expected=no_writeback", tag);
      end
      if (sb.size() != 0) begin
         w = sb.pop_front();
         chk({tag, ".wb_dst"}, 16'(bus.wb_dst), 16'(w.dst));
         chk({tag, ".wb_data"}, bus.wb_data, w.data);
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 8; i++) begin
         bus.dbg_rd_addr = 3'(i);
         #1;
         chk($sformatf("%s.R%0d", tag, i), bus.dbg_rd_data, 16'h0000);
      end
      chk({tag, ".flags"}, 16'(bus.flags), 16'h0);
   endtask

   task automatic do_op(input string name, input logic [3:0] f, input logic [2:0] dst,
                        input logic [2:0] src, input logic ui, input logic [15:0] imm,
                        input logic uc, input logic wr, input logic fe);
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [19:0] e;
      int          n;
      n = 0;
      while (!bus.issue_ready && n < 20) begin
         tick();
         n++;
      end
      chk({name, ".ready"}, 16'(bus.issue_ready), 16'h1);
      a   = ui ? imm : mreg[src];
      b   = mreg[dst];
      cin = uc ? mflags[3] : 1'b0;
      e   = (f == 4'h8 && a == 16'h0) ? {4'b0011, 16'hFFFF} : ref_alu(f, a, b, cin);
      if (wr) sb.push_back('{dst, e[15:0]});
      bus.issue_func = f; bus.issue_dst = dst; bus.issue_src = src;
      bus.issue_use_imm = ui; bus.issue_imm = imm; bus.issue_use_carry = uc;
      bus.issue_wr_en = wr; bus.issue_flag_en = fe; bus.issue_valid = 1'b1;
      tick();
      bus.issue_valid = 1'b0;
      chk({name, ".alu_a"}, bus.alu_a, a);
      chk({name, ".alu_b"}, bus.alu_b, b);
      chk({name, ".alu_func"}, 16'(bus.alu_func), 16'(f));
      chk({name, ".alu_cin"}, 16'(bus.alu_cin), 16'(cin));
      chk({name, ".busy"}, 16'(bus.issue_ready), 16'h0);
      tick();
      chk({name, ".wb_valid"}, 16'(bus.wb_valid), 16'(wr));
      if (bus.wb_valid) check_wb(name);
      if (wr) mreg[dst] = e[15:0];
      if (fe) mflags = e[19:16];
      tick();
      chk({name, ".flags"}, 16'(bus.flags), 16'(mflags));
      bus.dbg_rd_addr = dst;
      #1;
      chk({name, ".rdst"}, bus.dbg_rd_data, mreg[dst]);
      $display("op %s dst=%0d a=%h b=%h -> R=%h flags=%h", name, dst, a, b, mreg[dst], mflags);
   endtask

   initial begin
      int acc [$];
      rst = 1'b1;
      bus.issue_valid = 1'b0; bus.issue_func = 4'h0; bus.issue_dst = 3'd0;
      bus.issue_src = 3'd0; bus.issue_use_imm = 1'b0; bus.issue_imm = 16'h0;
      bus.issue_use_carry = 1'b0; bus.issue_wr_en = 1'b0; bus.issue_flag_en = 1'b0;
      bus.dbg_rd_addr = 3'd0;
      for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
      mflags = 4'h0;

      tick(); tick();
      chk("rst.ready_low", 16'(bus.issue_ready), 16'h0);
      chk("rst.wb_valid", 16'(bus.wb_valid), 16'h0);
      chk("rst.wb_data", bus.wb_data, 16'h0);
      chk("rst.alu_a", bus.alu_a, 16'h0);
      rst = 1'b0;
      tick();
      chk("rst.ready_high", 16'(bus.issue_ready), 16'h1);
      check_all_zero("rst");
      $display("reset released");

      do_op("imm_load", 4'h2, 3'd1, 3'd0, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b0);
      chk("imm_load.R1", bus.dbg_rd_data, 16'h1234);
      do_op("set_r1", 4'h2, 3'd1, 3'd0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      do_op("set_r2", 4'h2, 3'd2, 3'd0, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0);
      do_op("add_carry", 4'h0, 3'd2, 3'd1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
      chk("add_carry.R2", bus.dbg_rd_data, 16'h0000);
      chk("add_carry.flags_c1z1", 16'(bus.flags), 16'hC);
      do_op("adc", 4'h0, 3'd3, 3'd0, 1'b1, 16'h0, 1'b1, 1'b1, 1'b0);
      chk("adc.R3", bus.dbg_rd_data, 16'h0001);
      do_op("set_r4", 4'h2, 3'd4, 3'd0, 1'b1, 16'h0010, 1'b0, 1'b1, 1'b0);
      do_op("div0", 4'h8, 3'd4, 3'd0, 1'b1, 16'h0, 1'b0, 1'b1, 1'b1);
      chk("div0.R4", bus.dbg_rd_data, 16'hFFFF);
      chk("div0.flags_v1s1", 16'(bus.flags), 16'h3);
      do_op("div16", 4'h8, 3'd4, 3'd0, 1'b1, 16'h0010, 1'b0, 1'b1, 1'b0);
      do_op("set_r5", 4'h2, 3'd5, 3'd0, 1'b1, 16'h0007, 1'b0, 1'b1, 1'b0);
      do_op("cmp", 4'h1, 3'd5, 3'd0, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b1);
      chk("cmp.R5", bus.dbg_rd_data, 16'h0007);
      chk("cmp.Z", 16'(bus.flags[2]), 16'h1);
      do_op("func_e", 4'hE, 3'd0, 3'd1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
      do_op("src_eq_dst", 4'h0, 3'd1, 3'd1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);

      // valid held high: acceptance can only happen every third cycle
      bus.issue_func = 4'h0; bus.issue_dst = 3'd6; bus.issue_src = 3'd0;
      bus.issue_use_imm = 1'b1; bus.issue_imm = 16'h0001; bus.issue_use_carry = 1'b0;
      bus.issue_wr_en = 1'b1; bus.issue_flag_en = 1'b0; bus.issue_valid = 1'b1;
      for (int cyc = 0; cyc < 9; cyc++) begin
         if (bus.issue_ready) begin
            acc.push_back(cyc);
            sb.push_back('{3'd6, mreg[6] + 16'h1});
            mreg[6] = mreg[6] + 16'h1;
            $display("b2b accept at cycle %0d", cyc);
         end
         if (bus.wb_valid) check_wb("b2b");
         tick();
      end
      bus.issue_valid = 1'b0;
      chk("b2b.count", 16'(acc.size()), 16'd3);
      for (int i = 0; i < acc.size(); i++)
         chk($sformatf("b2b.accept%0d", i), 16'(acc[i]), 16'(3 * i));
      bus.dbg_rd_addr = 3'd6;
      #1;
      chk("b2b.R6", bus.dbg_rd_data, 16'h0003);

      // abort: reset lands while an op to R7 is in EXEC
      bus.issue_func = 4'h2; bus.issue_dst = 3'd7; bus.issue_imm = 16'hABCD;
      bus.issue_use_imm = 1'b1; bus.issue_wr_en = 1'b1; bus.issue_flag_en = 1'b1;
      bus.issue_valid = 1'b1;
      tick();
      bus.issue_valid = 1'b0;
      chk("abort.in_exec", 16'(bus.issue_ready), 16'h0);
      rst = 1'b1;
      #1;
      chk("abort.ready_low", 16'(bus.issue_ready), 16'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort.wb_in_rst", 16'(bus.wb_valid), 16'h0);
      end
      rst = 1'b0;
      for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
      mflags = 4'h0;
      for (int i = 0; i < 4; i++) begin
         chk("abort.wb_after", 16'(bus.wb_valid), 16'h0);
         tick();
      end
      chk("abort.ready_high", 16'(bus.issue_ready), 16'h1);
      check_all_zero("abort");
      $display("abort done");

      do_op("post_rst", 4'h2, 3'd7, 3'd0, 1'b1, 16'h5A5A, 1'b0, 1'b1, 1'b1);
      chk("sb.drained", 16'(sb.size()), 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
